// File: rtl/partition_sequencer.sv
// Cycle sequencer: steps the emulated clock once every participating gate has
// finished tx and rx; bounded or free-running runs, graceful stop, watchdog.
module partition_sequencer #(
  parameter int GATE_NUMBER   = 4,
  parameter int CYCLE_WIDTH   = 16,
  parameter int TIMEOUT_WIDTH = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [CYCLE_WIDTH-1:0]   i_cycles,
  input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
  input  logic [GATE_NUMBER-1:0]   i_gate_mask,
  input  logic [GATE_NUMBER-1:0]   i_tx_ready,
  input  logic [GATE_NUMBER-1:0]   i_rx_ready,
  output logic                     o_gen_sync,
  output logic                     o_tx_start,
  output logic                     o_rx_pull,
  output logic                     o_clock,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout_err,
  output logic [GATE_NUMBER-1:0]   o_stall_gates,
  output logic [CYCLE_WIDTH-1:0]   o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_WAIT, S_STEP, S_DONE, S_ERROR
  } state_t;

  state_t                   state, state_nx;
  logic [CYCLE_WIDTH-1:0]   target, count_inc;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt, wait_inc;
  logic [GATE_NUMBER-1:0]   gate_ok;
  logic                     all_ready;
  logic                     start_run, clr_wait, inc_wait, step_cnt, trip;

  // A masked-out gate always counts as ready, so an empty mask never blocks.
  for (genvar g = 0; g < GATE_NUMBER; g++) begin : g_gate
    assign gate_ok[g] = (i_tx_ready[g] & i_rx_ready[g]) | ~i_gate_mask[g];
  end
  assign all_ready = &gate_ok;

  assign count_inc = o_cycle_count + CYCLE_WIDTH'(1);
  assign wait_inc  = wait_cnt + TIMEOUT_WIDTH'(1);

  always_comb begin
    state_nx   = state;
    o_gen_sync = 1'b0;
    o_tx_start = 1'b0;
    o_rx_pull  = 1'b0;
    o_clock    = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    start_run  = 1'b0;
    clr_wait   = 1'b0;
    inc_wait   = 1'b0;
    step_cnt   = 1'b0;
    trip       = 1'b0;
    case (state)
      S_IDLE: begin
        o_gen_sync = 1'b1;
        o_busy     = 1'b0;
        if (i_start) begin
          state_nx  = S_PRIME;
          start_run = 1'b1;
        end
      end
      S_PRIME: begin
        o_tx_start = 1'b1;
        clr_wait   = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        if (i_stop)          state_nx = S_DONE;
        else if (all_ready)  state_nx = S_STEP;
        else if (i_timeout != '0 && wait_inc == i_timeout) begin
          state_nx = S_ERROR;
          trip     = 1'b1;
        end else inc_wait = 1'b1;
      end
      S_STEP: begin
        o_tx_start = 1'b1;
        o_rx_pull  = 1'b1;
        o_clock    = 1'b1;
        step_cnt   = 1'b1;
        // The step in flight is always counted, even when a stop arrives now.
        if (i_stop || (target != '0 && count_inc == target)) state_nx = S_DONE;
        else begin
          state_nx = S_WAIT;
          clr_wait = 1'b1;
        end
      end
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      target        <= '0;
      wait_cnt      <= '0;
      o_cycle_count <= '0;
      o_timeout_err <= 1'b0;
      o_stall_gates <= '0;
    end else begin
      state <= state_nx;
      if (start_run) begin
        target        <= i_cycles;
        o_cycle_count <= '0;
        o_timeout_err <= 1'b0;
        o_stall_gates <= '0;
      end
      if (clr_wait)      wait_cnt <= '0;
      else if (inc_wait) wait_cnt <= wait_inc;
      if (step_cnt) o_cycle_count <= count_inc;
      if (trip) begin
        o_timeout_err <= 1'b1;
        o_stall_gates <= i_gate_mask & ~(i_tx_ready & i_rx_ready);
      end
    end
  end

endmodule

// File: tb/tb_partition_sequencer.sv
// Scoreboarded bench for partition_sequencer: expected run results are queued
// at launch and compared when the run reaches DONE or ERROR.
module tb_partition_sequencer;
  localparam int G = 4, CW = 16, TW = 12;

  logic          clk = 1'b0;
  logic          rst, start, stop, start_w;
  logic [CW-1:0] cycles;
  logic [2:0]    cycles_w;
  logic [TW-1:0] timeout;
  logic [G-1:0]  mask, tx, rx;

  logic          o_gen_sync, o_tx_start, o_rx_pull, o_clock, o_busy, o_done, o_timeout_err;
  logic [G-1:0]  o_stall_gates;
  logic [CW-1:0] o_cycle_count;

  logic          w_gen_sync, w_tx_start, w_rx_pull, w_clock, w_busy, w_done, w_timeout_err;
  logic [G-1:0]  w_stall_gates;
  logic [2:0]    w_cycle_count;

  partition_sequencer #(.GATE_NUMBER(G), .CYCLE_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_cycles(cycles),
    .i_timeout(timeout), .i_gate_mask(mask), .i_tx_ready(tx), .i_rx_ready(rx),
    .o_gen_sync(o_gen_sync), .o_tx_start(o_tx_start), .o_rx_pull(o_rx_pull),
    .o_clock(o_clock), .o_busy(o_busy), .o_done(o_done), .o_timeout_err(o_timeout_err),
    .o_stall_gates(o_stall_gates), .o_cycle_count(o_cycle_count));

  partition_sequencer #(.GATE_NUMBER(G), .CYCLE_WIDTH(3), .TIMEOUT_WIDTH(TW)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_start(start_w), .i_stop(stop), .i_cycles(cycles_w),
    .i_timeout(timeout), .i_gate_mask(mask), .i_tx_ready(tx), .i_rx_ready(rx),
    .o_gen_sync(w_gen_sync), .o_tx_start(w_tx_start), .o_rx_pull(w_rx_pull),
    .o_clock(w_clock), .o_busy(w_busy), .o_done(w_done), .o_timeout_err(w_timeout_err),
    .o_stall_gates(w_stall_gates), .o_cycle_count(w_cycle_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          done;
    logic          err;
    logic [G-1:0]  stall;
    logic [CW-1:0] count;
  } res_t;

  res_t exp_q[$];
  int   total = 0, passed = 0;

  logic [26:0] outs, w_outs;
  localparam logic [26:0] RST_OUTS = {1'b1, 26'd0};
  assign outs   = {o_gen_sync, o_tx_start, o_rx_pull, o_clock, o_busy, o_done,
                   o_timeout_err, o_stall_gates, o_cycle_count};
  assign w_outs = {w_gen_sync, w_tx_start, w_rx_pull, w_clock, w_busy, w_done,
                   w_timeout_err, w_stall_gates, 13'd0, w_cycle_count};

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of PRIME (cycle c1).
  task automatic kick(input logic [CW-1:0] n);
    cycles = n;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Waits (bounded) for DONE or ERROR and snapshots the result there.
  task automatic collect(input int budget, output int n, output res_t r);
    n = 0;
    while (!(o_done || (o_busy && o_timeout_err)) && n < budget) begin
      tick();
      n++;
    end
    r = {o_done, o_timeout_err, o_stall_gates, o_cycle_count};
  endtask

  task automatic ready_all();
    mask = '1; tx = '1; rx = '1; timeout = '0; stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_w = 1'b0; stop = 1'b0;
    cycles = '0; cycles_w = '0; timeout = '0; mask = '1; tx = '1; rx = '1;
    tick(); tick();
    total++;
    if (outs !== RST_OUTS) $display("FAIL reset_outs got %h want %h", outs, RST_OUTS);
    else passed++;
    total++;
    if (w_outs !== RST_OUTS) $display("FAIL reset_outs_w got %h want %h", w_outs, RST_OUTS);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [9:0] rx_tr, done_tr, busy_tr;
    res_t e, r;
    ready_all();
    rx_tr = '0; done_tr = '0; busy_tr = '0; r = '0;
    exp_q.push_back({1'b1, 1'b0, 4'b0000, 16'd3});
    kick(3);
    for (int c = 1; c <= 9; c++) begin
      rx_tr[c]   = o_rx_pull;
      done_tr[c] = o_done;
      busy_tr[c] = o_busy;
      if (c == 8) r = {o_done, o_timeout_err, o_stall_gates, o_cycle_count};
      if (c < 9) tick();
    end
    e = exp_q.pop_front();
    total++;
    if (r !== e) $display("FAIL basic_result got %h want %h", r, e); else passed++;
    total++;
    if (rx_tr !== 10'b0010101000) $display("FAIL basic_rx_pull got %b want %b", rx_tr, 10'b0010101000);
    else passed++;
    total++;
    if (done_tr !== 10'b0100000000) $display("FAIL basic_done got %b want %b", done_tr, 10'b0100000000);
    else passed++;
    total++;
    if (busy_tr !== 10'b0111111110) $display("FAIL basic_busy got %b want %b", busy_tr, 10'b0111111110);
    else passed++;
  endtask

  task automatic test_mask();
    res_t e, r;
    int n;
    ready_all();
    mask = 4'b0111; rx = 4'b0111; timeout = 12'd5;
    exp_q.push_back({1'b1, 1'b0, 4'b0000, 16'd2});
    kick(2);
    collect(100, n, r);
    e = exp_q.pop_front();
    total++;
    if (r !== e || n !== 5) $display("FAIL mask_run got %h n=%0d want %h n=5", r, n, e);
    else passed++;
    tick();
    mask = 4'b1111;
    exp_q.push_back({1'b0, 1'b1, 4'b1000, 16'd0});
    kick(2);
    collect(100, n, r);
    e = exp_q.pop_front();
    total++;
    if (r !== e) $display("FAIL mask_timeout got %h want %h", r, e); else passed++;
    total++;
    if (n !== 6) $display("FAIL mask_timeout_cycle got %0d want 6", n); else passed++;
    tick(); tick();
    total++;
    if ({o_busy, o_timeout_err, o_stall_gates} !== 6'b011000)
      $display("FAIL mask_sticky got %b want %b", {o_busy, o_timeout_err, o_stall_gates}, 6'b011000);
    else passed++;
  endtask

  task automatic test_stall_release();
    res_t e, r;
    int n;
    ready_all();
    rx = 4'b1101;
    exp_q.push_back({1'b1, 1'b0, 4'b0000, 16'd1});
    kick(1);
    repeat (7) tick();
    total++;
    if ({o_busy, o_tx_start, o_clock, o_timeout_err} !== 4'b1000)
      $display("FAIL stall_waiting got %b want %b", {o_busy, o_tx_start, o_clock, o_timeout_err}, 4'b1000);
    else passed++;
    rx = 4'b1111;
    tick();
    total++;
    if (o_clock !== 1'b1) $display("FAIL stall_release_step got %b want 1", o_clock); else passed++;
    collect(10, n, r);
    e = exp_q.pop_front();
    total++;
    if (r !== e) $display("FAIL stall_result got %h want %h", r, e); else passed++;
    tick();
  endtask

  task automatic test_stop();
    res_t e, r;
    int n;
    ready_all();
    exp_q.push_back({1'b1, 1'b0, 4'b0000, 16'd1});
    kick(0);
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    collect(100, n, r);
    e = exp_q.pop_front();
    total++;
    if (r !== e || n !== 0) $display("FAIL stop_in_wait got %h n=%0d want %h n=0", r, n, e);
    else passed++;
    tick();
    exp_q.push_back({1'b1, 1'b0, 4'b0000, 16'd2});
    kick(0);
    repeat (4) tick();
    total++;
    if (o_clock !== 1'b1) $display("FAIL stop_step_phase got %b want 1", o_clock); else passed++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    collect(100, n, r);
    e = exp_q.pop_front();
    total++;
    if (r !== e || n !== 0) $display("FAIL stop_in_step got %h n=%0d want %h n=0", r, n, e);
    else passed++;
    tick();
  endtask

  task automatic test_wrap();
    res_t e, r;
    ready_all();
    cycles_w = 3'd0;
    exp_q.push_back({1'b1, 1'b0, 4'b0000, 16'd2});
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    repeat (21) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    r = {w_done, w_timeout_err, w_stall_gates, 13'd0, w_cycle_count};
    e = exp_q.pop_front();
    total++;
    if (r !== e) $display("FAIL wrap_count got %h want %h", r, e); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    ready_all();
    kick(5);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (outs !== RST_OUTS) $display("FAIL reset_mid got %h want %h", outs, RST_OUTS); else passed++;
    tick();
  endtask

  task automatic test_ignore();
    res_t e, r;
    int n;
    ready_all();
    exp_q.push_back({1'b1, 1'b0, 4'b0000, 16'd2});
    kick(2);
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(100, n, r);
    e = exp_q.pop_front();
    total++;
    if (r !== e) $display("FAIL ignore_step_run got %h want %h", r, e); else passed++;
    tick(); tick();
    total++;
    if (o_busy !== 1'b0) $display("FAIL ignore_step_start got %b want 0", o_busy); else passed++;
    rx = 4'b1110; timeout = 12'd3;
    exp_q.push_back({1'b0, 1'b1, 4'b0001, 16'd0});
    kick(1);
    collect(100, n, r);
    e = exp_q.pop_front();
    total++;
    if (r !== e) $display("FAIL ignore_err_run got %h want %h", r, e); else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    total++;
    if ({o_busy, o_timeout_err} !== 2'b01)
      $display("FAIL ignore_err_start got %b want %b", {o_busy, o_timeout_err}, 2'b01);
    else passed++;
    rx = 4'b1111;
    exp_q.push_back({1'b1, 1'b0, 4'b0000, 16'd1});
    kick(1);
    total++;
    if ({o_busy, o_timeout_err, o_stall_gates} !== 6'b100000)
      $display("FAIL restart_clears got %b want %b", {o_busy, o_timeout_err, o_stall_gates}, 6'b100000);
    else passed++;
    collect(100, n, r);
    e = exp_q.pop_front();
    total++;
    if (r !== e) $display("FAIL restart_run got %h want %h", r, e); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_stall_release();
    test_stop();
    test_wrap();
    test_reset_mid();
    test_ignore();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog got no finish want finish");
    $fatal(1);
  end

endmodule
